// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the front end.
//   XLEN / ILEN    : data and instruction widths
//   RESET_VECTOR   : default first fetch address
//   fetch_entry_t  : {pc, instr} pair carried through the fetch buffers
//   align_pc()     : force a PC onto a word boundary
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush.
//   clk, rst_n  : clock, async active-low reset (storage zeroed)
//   push/data   : write one entry
//   pop         : drop the head entry
//   flush       : empty the FIFO; wins over push and pop
//   head        : current head entry (registered storage, no bypass)
//   count       : number of stored entries (0..DEPTH)
//   full/empty  : status flags
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only safe when the head leaves the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> (!full || pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (pop && !flush) |-> !empty);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
//   clk, rst_n                : clock, async active-low reset
//   imem_req_*                : fetch request (valid/ready, word address)
//   imem_rsp_valid/data       : in-order responses, never back-pressured
//   redirect_valid/pc         : one-cycle control-flow change
//   instr_valid/ready         : handshake to decode
//   instruction, instr_pc     : head of the instruction buffer
// Requests are credit limited: in-flight requests plus buffered words never
// exceed DEPTH, so the buffer can always absorb every response.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc;
    logic          running;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] buf_count;
    logic [CW:0]   credit_used;
    logic          accept;
    logic          rsp_keep;
    logic          pop;
    fetch_entry_t  tag_in;
    fetch_entry_t  tag_head;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;
    logic          tag_full;
    logic          tag_empty;
    logic          buf_full;
    logic          buf_empty;

    // Credit uses registered counts only; a pop this cycle frees its slot next cycle.
    assign credit_used    = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid = running && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses for requests issued before a redirect are swallowed via drop_cnt.
    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
    assign pop      = instr_valid && instr_ready;

    // `running` holds requests off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            running <= 1'b0;
        end else begin
            running <= 1'b1;
            if (redirect_valid) pc <= align_pc(redirect_pc);
            else if (accept)    pc <= pc + 32'd4;
        end
    end

    // Everything still in flight at a redirect is stale, except that a response
    // landing in the redirect cycle is dropped directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            drop_cnt <= outstanding - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - 1'b1;
        end
    end

    // PC tags of in-flight requests; its occupancy is the outstanding count.
    // Every response pops a tag, kept or dropped, so it is never flushed.
    assign tag_in = '{pc: pc, instr: '0};

    fetch_fifo #(.DEPTH(DEPTH)) u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (tag_in),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .head      (tag_head),
        .count     (outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign buf_in = '{pc: tag_head.pc, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (buf_in),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign instr_valid = !buf_empty;
    assign instruction = buf_head.instr;
    assign instr_pc    = buf_head.pc;

    logic unused_bits;
    assign unused_bits = ^{tag_head.instr, redirect_pc[1:0], tag_full, tag_empty, buf_full};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable in-order memory model
// and a pop recorder feed per-scenario tasks with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int lat  = 1;
    int n_acc = 0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    logic [63:0] got[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model and handshake recorder; samples mid-cycle, well away from posedge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memw(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #2;
        if (rst_n && imem_req_valid && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            n_acc++;
        end
        if (rst_n && instr_valid && instr_ready && !redirect_valid)
            got.push_back({instr_pc, instruction});
    end

    task automatic wait_got(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        got.delete();
        n_acc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        got.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        nvec++; if (imem_req_addr !== 32'h0) begin nerr++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        nvec++; if (instruction !== 32'h0) begin nerr++; $display("FAIL reset_instruction: got %h want 00000000", instruction); end
        nvec++; if (instr_pc !== 32'h0) begin nerr++; $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); end
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat            = 1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL release_req_valid_pre: got %b want 0", imem_req_valid); end
        @(negedge clk);
        nvec++; if (imem_req_valid !== 1'b1) begin nerr++; $display("FAIL release_req_valid: got %b want 1", imem_req_valid); end
        nvec++; if (imem_req_addr !== 32'h0) begin nerr++; $display("FAIL release_req_addr: got %h want 00000000", imem_req_addr); end
    endtask

    task automatic test_stream();
        wait_got(12, 60);
        nvec++;
        if (got.size() < 12) begin
            nerr++; $display("FAIL stream_count: got %0d want 12", got.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                nvec++; if (got[i][63:32] !== 32'(i*4)) begin nerr++; $display("FAIL stream_pc[%0d]: got %h want %h", i, got[i][63:32], 32'(i*4)); end
                nvec++; if (got[i][31:0] !== memw(32'(i*4))) begin nerr++; $display("FAIL stream_instr[%0d]: got %h want %h", i, got[i][31:0], memw(32'(i*4))); end
            end
        end
    endtask

    task automatic test_decode_stall();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                nvec++; if (instr_pc !== 32'h0) begin nerr++; $display("FAIL stall_head_pc: got %h want 00000000", instr_pc); end
            end
        end
        nvec++; if (n_acc !== 2) begin nerr++; $display("FAIL stall_requests: got %0d want 2", n_acc); end
        nvec++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
        nvec++; if (instruction !== memw(32'h0)) begin nerr++; $display("FAIL stall_instr: got %h want %h", instruction, memw(32'h0)); end
        instr_ready = 1'b1;
        wait_got(8, 60);
        nvec++;
        if (got.size() < 8) begin
            nerr++; $display("FAIL stall_release_count: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                nvec++; if (got[i] !== {32'(i*4), memw(32'(i*4))}) begin nerr++; $display("FAIL stall_release[%0d]: got %h want %h", i, got[i], {32'(i*4), memw(32'(i*4))}); end
            end
        end
    endtask

    task automatic test_req_stall();
        logic [31:0] a0;
        int          acc0;
        @(negedge clk);
        imem_req_ready = 1'b0;
        acc0 = n_acc;
        a0   = 32'(acc0 * 4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nvec++; if (imem_req_addr !== a0) begin nerr++; $display("FAIL req_stall_addr: got %h want %h", imem_req_addr, a0); end
        end
        nvec++; if (n_acc !== acc0) begin nerr++; $display("FAIL req_stall_accepts: got %0d want %0d", n_acc, acc0); end
        imem_req_ready = 1'b1;
        wait_got(acc0 + 4, 40);
        nvec++;
        if (got.size() < acc0 + 4) begin
            nerr++; $display("FAIL req_stall_count: got %0d want %0d", got.size(), acc0 + 4);
        end else begin
            for (int j = 0; j < 4; j++) begin
                nvec++; if (got[acc0+j][63:32] !== a0 + 32'(j*4)) begin nerr++; $display("FAIL req_stall_pc[%0d]: got %h want %h", j, got[acc0+j][63:32], a0 + 32'(j*4)); end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        lat = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        do_reset();
        for (int k = 0; k < 10 && n_acc < 2; k++) @(negedge clk);
        nvec++; if (n_acc !== 2) begin nerr++; $display("FAIL redir_inflight: got %0d want 2", n_acc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        got.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        nvec++; if (imem_req_addr !== 32'h100) begin nerr++; $display("FAIL redir_addr: got %h want 00000100", imem_req_addr); end
        wait_got(2, 40);
        nvec++;
        if (got.size() < 2) begin
            nerr++; $display("FAIL redir_count: got %0d want 2", got.size());
        end else begin
            nvec++; if (got[0] !== {32'h100, memw(32'h100)}) begin nerr++; $display("FAIL redir_first: got %h want %h", got[0], {32'h100, memw(32'h100)}); end
            nvec++; if (got[1][63:32] !== 32'h104) begin nerr++; $display("FAIL redir_second: got %h want 00000104", got[1][63:32]); end
        end
    endtask

    task automatic test_redirect_live();
        lat = 1;
        repeat (4) @(negedge clk);
        do_redirect(32'h0000_0200);
        wait_got(3, 40);
        nvec++;
        if (got.size() < 3) begin
            nerr++; $display("FAIL live_count: got %0d want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nvec++; if (got[i] !== {32'h200 + 32'(i*4), memw(32'h200 + 32'(i*4))}) begin nerr++; $display("FAIL live[%0d]: got %h", i, got[i]); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        exp_pc[3] = 32'h0000_0004;
        do_redirect(32'hFFFF_FFF8);
        wait_got(4, 40);
        nvec++;
        if (got.size() < 4) begin
            nerr++; $display("FAIL wrap_count: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nvec++; if (got[i] !== {exp_pc[i], memw(exp_pc[i])}) begin nerr++; $display("FAIL wrap[%0d]: got %h want %h", i, got[i], {exp_pc[i], memw(exp_pc[i])}); end
            end
        end
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        nvec++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL areset_pre_valid: got %b want 1", instr_valid); end
        #1 rst_n = 1'b0;
        #1;
        nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
        nvec++; if (instr_pc !== 32'h0) begin nerr++; $display("FAIL areset_pc: got %h want 00000000", instr_pc); end
        nvec++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL areset_req_valid: got %b want 0", imem_req_valid); end
        @(negedge clk);
        got.delete();
        n_acc = 0;
        instr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_got(3, 40);
        nvec++;
        if (got.size() < 3) begin
            nerr++; $display("FAIL areset_count: got %0d want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nvec++; if (got[i][63:32] !== 32'(i*4)) begin nerr++; $display("FAIL areset_restart[%0d]: got %h want %h", i, got[i][63:32], 32'(i*4)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_decode_stall();
        test_req_stall();
        test_redirect_inflight();
        test_redirect_live();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
